// File: rtl/ram_bist_engine_if.sv
// Single-port RAM bus between the BIST engine (master) and the RAM under test (slave).
// Read data is expected RD_LAT cycles after a cycle with ram_re_o high.
interface ram_bist_engine_if #(
    parameter int DW = 32,
    parameter int AW = 10
);
    logic [AW-1:0] ram_addr_o;
    logic          ram_we_o;
    logic          ram_re_o;
    logic [DW-1:0] ram_wdata_o;
    logic [DW-1:0] ram_rdata_i;

    modport master (
        output ram_addr_o, ram_we_o, ram_re_o, ram_wdata_o,
        input  ram_rdata_i
    );

    modport slave (
        input  ram_addr_o, ram_we_o, ram_re_o, ram_wdata_o,
        output ram_rdata_i
    );
endinterface

// File: rtl/ram_bist_engine.sv
// Memory BIST engine: sweeps an external RAM with ADDR, CHECKER, March C- or FILL0
// element lists and reports pass/fail, a saturating error count and the first failing address.
module ram_bist_engine #(
    parameter int DW           = 32,
    parameter int AW           = 10,
    parameter int RD_LAT       = 1,
    parameter int ERR_CNT_W    = 16,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic                 ss_clk_in,
    input  logic                 ss_reset_n_in,
    input  logic                 start_in,
    input  logic [1:0]           mode_in,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic                 first_fail_valid_o,
    output logic [AW-1:0]        first_fail_addr_o,
    output logic [2:0]           dbg_state_o,
    ram_bist_engine_if.master    ram
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_ISSUE, S_RD_WAIT, S_DONE} state_t;
    typedef enum logic [2:0] {P_0, P_1, P_A, P_C, P_NC} pat_t;

    localparam logic [1:0] MODE_ADDR    = 2'd0;
    localparam logic [1:0] MODE_CHECKER = 2'd1;
    localparam logic [1:0] MODE_MARCH   = 2'd2;
    localparam logic       WAIT_LAST    = 1'(RD_LAT - 1);

    // Algorithm tables, indexed by (mode, element, op-within-element).
    function automatic logic op_rd(input logic [1:0] m, input logic [2:0] e, input logic op);
        case (m)
            MODE_ADDR:    op_rd = (e == 3'd1);
            MODE_CHECKER: op_rd = e[0];
            MODE_MARCH:   op_rd = (e != 3'd0) && !op;
            default:      op_rd = 1'b0;
        endcase
    endfunction

    function automatic pat_t op_pat(input logic [1:0] m, input logic [2:0] e, input logic op);
        case (m)
            MODE_ADDR:    op_pat = P_A;
            MODE_CHECKER: op_pat = (e < 3'd2) ? P_C : P_NC;
            MODE_MARCH: begin
                if (e == 3'd1 || e == 3'd3)      op_pat = op ? P_1 : P_0;
                else if (e == 3'd2 || e == 3'd4) op_pat = op ? P_0 : P_1;
                else                             op_pat = P_0;
            end
            default:      op_pat = P_0;
        endcase
    endfunction

    function automatic logic elem_down(input logic [1:0] m, input logic [2:0] e);
        elem_down = (m == MODE_MARCH) && (e == 3'd3 || e == 3'd4);
    endfunction

    function automatic logic elem_two(input logic [1:0] m, input logic [2:0] e);
        elem_two = (m == MODE_MARCH) && (e >= 3'd1) && (e <= 3'd4);
    endfunction

    function automatic logic elem_last(input logic [1:0] m, input logic [2:0] e);
        case (m)
            MODE_ADDR:    elem_last = (e == 3'd1);
            MODE_CHECKER: elem_last = (e == 3'd3);
            MODE_MARCH:   elem_last = (e == 3'd5);
            default:      elem_last = 1'b1;
        endcase
    endfunction

    function automatic logic [DW-1:0] pat_val(input pat_t p, input logic [AW-1:0] a);
        logic [DW-1:0] v;
        for (int i = 0; i < DW; i++) begin
            case (p)
                P_1:     v[i] = 1'b1;
                P_A:     v[i] = a[i % AW];
                P_C:     v[i] = i[0] ^ a[0];
                P_NC:    v[i] = ~(i[0] ^ a[0]);
                default: v[i] = 1'b0;
            endcase
        end
        return v;
    endfunction

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [2:0]            elem_q, elem_d;
    logic                  op_q, op_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  wait_q, wait_d;
    logic [ERR_CNT_W-1:0]  err_q, err_d;
    logic                  ffv_q, ffv_d;
    logic [AW-1:0]         ffa_q, ffa_d;
    logic                  pass_q, pass_d;

    logic [DW-1:0] exp_data;
    logic          cur_down, last_addr, mismatch;
    logic [2:0]    adv_elem;
    logic          adv_op, adv_fin;
    logic [AW-1:0] adv_addr;
    state_t        adv_state;

    assign exp_data  = pat_val(op_pat(mode_q, elem_q, op_q), addr_q);
    assign cur_down  = elem_down(mode_q, elem_q);
    assign last_addr = cur_down ? (addr_q == '0) : (addr_q == '1);
    assign mismatch  = (ram.ram_rdata_i != exp_data);

    // Position of the op that follows the current one: next op, next address, next element or end.
    always_comb begin
        adv_elem = elem_q;
        adv_op   = 1'b0;
        adv_addr = addr_q;
        adv_fin  = 1'b0;
        if (!op_q && elem_two(mode_q, elem_q)) begin
            adv_op = 1'b1;
        end else if (!last_addr) begin
            adv_addr = cur_down ? addr_q - 1'b1 : addr_q + 1'b1;
        end else if (!elem_last(mode_q, elem_q)) begin
            adv_elem = elem_q + 3'd1;
            adv_addr = elem_down(mode_q, adv_elem) ? '1 : '0;
        end else begin
            adv_fin = 1'b1;
        end
        if (adv_fin)                               adv_state = S_DONE;
        else if (op_rd(mode_q, adv_elem, adv_op))  adv_state = S_RD_ISSUE;
        else                                       adv_state = S_WR;
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        elem_d  = elem_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wait_d  = wait_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffa_d   = ffa_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_in) begin
                    mode_d  = mode_in;
                    elem_d  = 3'd0;
                    op_d    = 1'b0;
                    addr_d  = elem_down(mode_in, 3'd0) ? '1 : '0;
                    wait_d  = 1'b0;
                    err_d   = '0;
                    ffv_d   = 1'b0;
                    ffa_d   = '0;
                    pass_d  = 1'b0;
                    state_d = op_rd(mode_in, 3'd0, 1'b0) ? S_RD_ISSUE : S_WR;
                end
            end
            S_WR: begin
                elem_d  = adv_elem;
                op_d    = adv_op;
                addr_d  = adv_addr;
                state_d = adv_state;
            end
            S_RD_ISSUE: begin
                wait_d  = 1'b0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    if (mismatch) begin
                        err_d = (err_q == '1) ? err_q : err_q + 1'b1;
                        if (!ffv_q) begin
                            ffv_d = 1'b1;
                            ffa_d = addr_q;
                        end
                    end
                    if (mismatch && STOP_ON_FAIL) begin
                        state_d = S_DONE;
                    end else begin
                        elem_d  = adv_elem;
                        op_d    = adv_op;
                        addr_d  = adv_addr;
                        state_d = adv_state;
                    end
                end else begin
                    wait_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Verdict is latched on the transition so it includes a mismatch from the final compare.
        if (state_d == S_DONE && state_q != S_DONE) begin
            pass_d = (err_d == '0);
        end
    end

    always_ff @(posedge ss_clk_in or negedge ss_reset_n_in) begin
        if (!ss_reset_n_in) begin
            state_q <= S_IDLE;
            mode_q  <= 2'd0;
            elem_q  <= 3'd0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            wait_q  <= 1'b0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffa_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            elem_q  <= elem_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffa_q   <= ffa_d;
            pass_q  <= pass_d;
        end
    end

    assign ram.ram_we_o    = (state_q == S_WR);
    assign ram.ram_re_o    = (state_q == S_RD_ISSUE);
    assign ram.ram_addr_o  = addr_q;
    assign ram.ram_wdata_o = (state_q == S_WR) ? exp_data : '0;

    assign busy_o             = (state_q == S_WR) || (state_q == S_RD_ISSUE) || (state_q == S_RD_WAIT);
    assign done_o             = (state_q == S_DONE);
    assign pass_o             = pass_q;
    assign err_cnt_o          = err_q;
    assign first_fail_valid_o = ffv_q;
    assign first_fail_addr_o  = ffa_q;
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_ram_bist_engine.sv
// Bench for ram_bist_engine: four configurations share one clock, each with a faultable RAM model;
// a reference model derived from the algorithm text predicts RAM ops and final status.
module tb_ram_bist_engine;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int NI = 4;

    function automatic int lat_of(input int g);  return (g == 2) ? 2 : 1;  endfunction
    function automatic int stop_of(input int g); return (g == 1) ? 1 : 0;  endfunction
    function automatic int ecw_of(input int g);  return (g == 3) ? 2 : 16; endfunction

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_r [NI];
    logic [1:0] mode_r  [NI];
    logic       busy_w [NI], done_w [NI], pass_w [NI], ffv_w [NI], we_w [NI], re_w [NI];
    logic [15:0] err_w [NI];
    logic [1:0]  ffa_w [NI], addr_w [NI];
    logic [7:0]  wdata_w [NI];
    logic [2:0]  st_w [NI];
    logic [7:0]  and_m [NI][4];
    logic [7:0]  or_m  [NI][4];

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int ECW = ecw_of(g);
        ram_bist_engine_if #(.DW(DW), .AW(AW)) rif ();
        logic [ECW-1:0] err;
        logic [7:0] mem [4];
        logic [7:0] rd1, rd2;

        ram_bist_engine #(.DW(DW), .AW(AW), .RD_LAT(lat_of(g)), .ERR_CNT_W(ECW),
                          .STOP_ON_FAIL(stop_of(g) == 1)) dut (
            .ss_clk_in(clk), .ss_reset_n_in(rst_n), .start_in(start_r[g]), .mode_in(mode_r[g]),
            .busy_o(busy_w[g]), .done_o(done_w[g]), .pass_o(pass_w[g]), .err_cnt_o(err),
            .first_fail_valid_o(ffv_w[g]), .first_fail_addr_o(ffa_w[g]),
            .dbg_state_o(st_w[g]), .ram(rif));

        // Stuck-at faults are applied on the read path so a faulty cell always reads its stuck value.
        always @(posedge clk) begin
            if (rif.ram_we_o) mem[rif.ram_addr_o] <= rif.ram_wdata_o;
            if (rif.ram_re_o) rd1 <= (mem[rif.ram_addr_o] & and_m[g][rif.ram_addr_o]) | or_m[g][rif.ram_addr_o];
            rd2 <= rd1;
        end
        assign rif.ram_rdata_i = (lat_of(g) == 2) ? rd2 : rd1;
        assign err_w[g]   = 16'(err);
        assign we_w[g]    = rif.ram_we_o;
        assign re_w[g]    = rif.ram_re_o;
        assign addr_w[g]  = rif.ram_addr_o;
        assign wdata_w[g] = rif.ram_wdata_o;
    end

    typedef struct packed {
        logic [15:0] cyc;
        logic [15:0] err;
        logic        ffv;
        logic [1:0]  ffa;
        logic        pass;
    } res_t;

    logic [10:0] exp_q [$];
    res_t        res_q [$];
    int n_tests = 0;
    int n_fail  = 0;
    int sel     = 0;
    bit mon_en  = 1'b0;
    int cyc_cnt = 0;
    bit prev_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (inst %0d, t=%0t)", name, act, exp, sel, $time);
        end
    endtask

    function automatic logic [7:0] pat(input byte c, input int a);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            case (c)
                "1":     v[i] = 1'b1;
                "A":     v[i] = 1'((a >> (i % AW)) & 1);
                "C":     v[i] = 1'((i & 1) ^ (a & 1));
                "N":     v[i] = 1'(1 - ((i & 1) ^ (a & 1)));
                default: v[i] = 1'b0;
            endcase
        end
        return v;
    endfunction

    // Reference: algorithms as text, elements split by '|', 'd' marks a down sweep.
    task automatic model_run(input int g, input int mode);
        string s;
        int ne, e, cycles, err, sat, ffa, lat;
        bit ffv, stopped;
        bit dn [8];
        int nop [8];
        byte opk [8][2];
        byte opv [8][2];
        logic [7:0] mem_m [4];
        logic [7:0] v, got;
        res_t r;
        case (mode)
            0:       s = "WA|RA";
            1:       s = "WC|RC|WN|RN";
            2:       s = "W0|R0W1|R1W0|dR0W1|dR1W0|R0";
            default: s = "W0";
        endcase
        for (int k = 0; k < 8; k++) begin dn[k] = 0; nop[k] = 0; end
        e = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "|") e++;
            else if (s[i] == "d") dn[e] = 1;
            else begin
                opk[e][nop[e]] = s[i];
                opv[e][nop[e]] = s[i+1];
                nop[e]++;
                i++;
            end
        end
        ne = e + 1;
        lat = lat_of(g);
        sat = (1 << ecw_of(g)) - 1;
        cycles = 0; err = 0; ffv = 0; ffa = 0; stopped = 0;
        for (int el = 0; el < ne; el++) begin
            for (int k = 0; k < 4; k++) begin
                int a;
                a = dn[el] ? 3 - k : k;
                for (int o = 0; o < nop[el]; o++) begin
                    v = pat(opv[el][o], a);
                    if (opk[el][o] == "W") begin
                        mem_m[a] = v;
                        exp_q.push_back({1'b0, 2'(a), v});
                        cycles += 1;
                    end else begin
                        exp_q.push_back({1'b1, 2'(a), 8'h00});
                        cycles += 1 + lat;
                        got = (mem_m[a] & and_m[g][a]) | or_m[g][a];
                        if (got != v) begin
                            if (err < sat) err++;
                            if (!ffv) begin ffv = 1; ffa = a; end
                            if (stop_of(g) == 1) stopped = 1;
                        end
                    end
                    if (stopped) break;
                end
                if (stopped) break;
            end
            if (stopped) break;
        end
        r.cyc = 16'(cycles); r.err = 16'(err); r.ffv = ffv; r.ffa = 2'(ffa); r.pass = (err == 0);
        res_q.push_back(r);
    endtask

    // Monitor: every RAM op and every end of busy is checked against the queued expectations.
    initial begin
        logic [10:0] e;
        res_t r;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (we_w[sel] || re_w[sel]) begin
                    if (exp_q.size() == 0) check("ram_op_extra", {re_w[sel], addr_w[sel]}, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("ram_op", {re_w[sel], addr_w[sel], re_w[sel] ? 8'h00 : wdata_w[sel]}, 32'(e));
                    end
                end
                if (busy_w[sel]) cyc_cnt++;
                if (prev_busy && !busy_w[sel]) begin
                    if (res_q.size() == 0) check("result_extra", 1, 0);
                    else begin
                        r = res_q.pop_front();
                        check("busy_cycles", cyc_cnt, 32'(r.cyc));
                        check("done", 32'(done_w[sel]), 1);
                        check("err_cnt", 32'(err_w[sel]), 32'(r.err));
                        check("ff_valid", 32'(ffv_w[sel]), 32'(r.ffv));
                        check("ff_addr", 32'(ffa_w[sel]), 32'(r.ffa));
                        check("pass", 32'(pass_w[sel]), 32'(r.pass));
                    end
                    cyc_cnt = 0;
                end
                prev_busy = busy_w[sel];
            end
        end
    end

    task automatic clear_faults();
        for (int g = 0; g < NI; g++)
            for (int a = 0; a < 4; a++) begin and_m[g][a] = 8'hFF; or_m[g][a] = 8'h00; end
    endtask

    task automatic run(input int g, input int mode, input bit ign);
        bit fin;
        sel = g;
        model_run(g, mode);
        @(negedge clk);
        start_r[g] = 1'b1;
        mode_r[g]  = 2'(mode);
        @(negedge clk);
        start_r[g] = 1'b0;
        check("start_clears", {done_w[g], err_w[g], ffv_w[g]}, 0);
        if (ign) begin
            @(negedge clk);
            start_r[g] = 1'b1;
            mode_r[g]  = 2'(mode) ^ 2'd1;
            @(negedge clk);
            start_r[g] = 1'b0;
        end
        fin = 0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (res_q.size() == 0) begin fin = 1; break; end
        end
        @(negedge clk);
        if (!fin) begin
            check("done_timeout", 0, 1);
            res_q.delete();
        end
        check("ops_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int g, m, f, a, b;
        for (int i = 0; i < NI; i++) begin start_r[i] = 1'b0; mode_r[i] = 2'd0; end
        clear_faults();
        #1;
        check("reset_flags", {busy_w[0], done_w[0], pass_w[0], ffv_w[0], we_w[0], re_w[0]}, 0);
        check("reset_vals", {err_w[0], ffa_w[0], addr_w[0], wdata_w[0]}, 0);
        check("reset_state_idle", 32'(st_w[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        run(0, 0, 0);                       // ADDR, fault-free
        and_m[0][2] = 8'hF7;
        run(0, 2, 0);                       // March C-, bit 3 of addr 2 stuck at 0
        and_m[1][2] = 8'hF7;
        run(1, 2, 0);                       // same fault, stop at first fail
        run(2, 1, 0);                       // CHECKER with RD_LAT=2
        for (int k = 0; k < 4; k++) or_m[3][k] = 8'h01;
        run(3, 2, 1);                       // saturation, start during busy ignored
        run(3, 3, 0);                       // new start clears status
        clear_faults();

        // Asynchronous reset in the middle of a March C- run.
        mon_en = 1'b0;
        sel = 0;
        @(negedge clk);
        start_r[0] = 1'b1;
        mode_r[0]  = 2'd2;
        @(negedge clk);
        start_r[0] = 1'b0;
        repeat (20) @(negedge clk);
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            if (we_w[0]) begin ok = 1; break; end
            @(negedge clk);
        end
        check("midtest_we_seen", 32'(ok), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_we", 32'(we_w[0]), 0);
        check("async_reset_flags", {busy_w[0], done_w[0], pass_w[0], ffv_w[0], re_w[0]}, 0);
        check("async_reset_vals", {err_w[0], ffa_w[0], addr_w[0], wdata_w[0]}, 0);
        check("async_reset_idle", 32'(st_w[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        for (int n = 0; n < 12; n++) begin
            clear_faults();
            g = $urandom_range(0, 3);
            m = $urandom_range(0, 3);
            f = $urandom_range(0, 2);
            a = $urandom_range(0, 3);
            b = $urandom_range(0, 7);
            if (f == 1) and_m[g][a] = ~(8'h01 << b);
            if (f == 2) or_m[g][a]  = 8'h01 << b;
            run(g, m, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
